// File: rtl/clb_cfg_loader.sv
// -----------------------------------------------------------------------------
// clb_cfg_loader
//
// Configuration front end for the CLB fabric. It receives a byte-wide frame
// (sync byte, CFG_BYTES payload bytes, XOR checksum) and assembles the payload
// in a shadow register. The image is committed to the fabric's config bus only
// when the checksum matches, so a partial or corrupt frame never reaches the
// LUT/routing configuration.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   cfg_data   in   [7:0]  configuration byte
//   cfg_valid  in   cfg_data valid this cycle
//   cfg_ready  out  loader accepts a byte this cycle (depends on state only)
//   cfg_abort  in   synchronous abort: drop the frame in progress, clear cfg_err
//   cfg_bits   out  [8*CFG_BYTES-1:0] committed configuration bus
//   cfg_load   out  one-cycle pulse when cfg_bits first shows a new image
//   cfg_done   out  sticky: at least one frame committed since reset
//   cfg_err    out  sticky checksum error, cleared by cfg_abort or reset
// -----------------------------------------------------------------------------
module clb_cfg_loader #(
    parameter int          CFG_BYTES = 4,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             cfg_data,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic                   cfg_abort,
    output logic [8*CFG_BYTES-1:0] cfg_bits,
    output logic                   cfg_load,
    output logic                   cfg_done,
    output logic                   cfg_err
);

    localparam int BUS_W = 8 * CFG_BYTES;
    localparam int CNT_W = (CFG_BYTES > 1) ? $clog2(CFG_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CFG_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_COMMIT,
        S_ERR
    } state_t;

    state_t             state;
    logic [BUS_W-1:0]   shadow;
    logic [7:0]         acc;
    logic [CNT_W-1:0]   cnt;
    logic               accept;

    // Ready is a pure function of state so upstream can never create a
    // combinational loop through cfg_valid.
    assign cfg_ready = (state == S_IDLE) || (state == S_LOAD) || (state == S_CHECK);
    assign accept    = cfg_valid && cfg_ready;

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the values from before the edge, independent of the
    // order of statements in the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            shadow   <= '0;
            acc      <= '0;
            cnt      <= '0;
            cfg_bits <= '0;
            cfg_load <= 1'b0;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            // NOTE: cfg_load defaults low every cycle; only the COMMIT branch
            // raises it, which makes it a single-cycle pulse by construction.
            cfg_load <= 1'b0;

            if (cfg_abort) begin
                // Abort wins over any byte presented in the same cycle.
                state   <= S_IDLE;
                cfg_err <= 1'b0;
                cnt     <= '0;
                acc     <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (accept && (cfg_data == SYNC_BYTE)) begin
                            state <= S_LOAD;
                            cnt   <= '0;
                            acc   <= '0;
                        end
                    end

                    S_LOAD: begin
                        if (accept) begin
                            // First payload byte lands in the LSBs.
                            shadow[8*cnt +: 8] <= cfg_data;
                            acc                <= acc ^ cfg_data;
                            if (cnt == LAST_IDX) begin
                                // Counter is left at the last index rather
                                // than wrapping; it is cleared on the next sync.
                                state <= S_CHECK;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end

                    S_CHECK: begin
                        if (accept) begin
                            if (cfg_data == acc) begin
                                state <= S_COMMIT;
                            end else begin
                                state   <= S_ERR;
                                cfg_err <= 1'b1;
                            end
                        end
                    end

                    S_COMMIT: begin
                        cfg_bits <= shadow;
                        cfg_load <= 1'b1;
                        cfg_done <= 1'b1;
                        state    <= S_IDLE;
                    end

                    S_ERR: begin
                        // Parked until cfg_abort; no bytes are accepted.
                    end

                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clb_cfg_loader.sv
module tb_clb_cfg_loader;

    localparam int         CFG_BYTES = 4;
    localparam logic [7:0] SYNC      = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  cfg_data = '0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic        cfg_abort = 1'b0;
    logic [31:0] cfg_bits;
    logic        cfg_load;
    logic        cfg_done;
    logic        cfg_err;

    clb_cfg_loader #(.CFG_BYTES(CFG_BYTES), .SYNC_BYTE(SYNC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_data  (cfg_data),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_abort (cfg_abort),
        .cfg_bits  (cfg_bits),
        .cfg_load  (cfg_load),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    int asserts = 0;
    int fails   = 0;

    // ---------------- reference model (frame-level view) ----------------
    // mode: 0 hunting for sync, 1 collecting payload, 2 awaiting checksum, 3 error
    int          m_mode = 0;
    logic [7:0]  m_payload[$];
    logic [31:0] m_bits = '0;
    logic        m_done = 1'b0;
    logic        m_err  = 1'b0;
    logic [31:0] exp_q[$];

    function automatic logic [31:0] pack_payload();
        logic [31:0] img = '0;
        for (int i = 0; i < CFG_BYTES; i++) img[8*i +: 8] = m_payload[i];
        return img;
    endfunction

    function automatic logic [7:0] xor_payload();
        logic [7:0] x = '0;
        foreach (m_payload[i]) x ^= m_payload[i];
        return x;
    endfunction

    task automatic model_accept(input logic [7:0] b);
        case (m_mode)
            0: if (b == SYNC) begin m_mode = 1; m_payload.delete(); end
            1: begin
                m_payload.push_back(b);
                if (m_payload.size() == CFG_BYTES) m_mode = 2;
            end
            2: begin
                if (b == xor_payload()) begin
                    m_bits = pack_payload();
                    m_done = 1'b1;
                    exp_q.push_back(m_bits);
                    m_mode = 0;
                end else begin
                    m_err  = 1'b1;
                    m_mode = 3;
                end
            end
            default: ;
        endcase
    endtask

    task automatic model_abort();
        m_mode = 0;
        m_err  = 1'b0;
        m_payload.delete();
    endtask

    task automatic model_reset();
        model_abort();
        m_bits = '0;
        m_done = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_bits"}, cfg_bits, m_bits);
        check({tag, "_done"}, {31'd0, cfg_done}, {31'd0, m_done});
        check({tag, "_err"},  {31'd0, cfg_err},  {31'd0, m_err});
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic prev_load = 1'b0;
    int   load_count = 0;
    bit   count_ready = 1'b0;
    int   ready_low = 0;

    always @(negedge clk) begin
        if (rst_n && cfg_load) begin
            load_count++;
            asserts++;
            if (prev_load) begin
                fails++;
                $display("FAIL load_width: cfg_load high two cycles running (t=%0t)", $time);
            end
            asserts++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_load: bits=%08h with no commit expected (t=%0t)", cfg_bits, $time);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (cfg_bits !== e) begin
                    fails++;
                    $display("FAIL load_bits: got %08h expected %08h (t=%0t)", cfg_bits, e, $time);
                end
            end
        end
        prev_load = rst_n && cfg_load;
        if (count_ready && !cfg_ready) ready_low++;
    end

    // ---------------- drivers (inputs change 1 time unit after posedge) ----------------
    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok = 1'b0;
        cfg_data  = b;
        cfg_valid = 1'b1;
        for (int t = 0; t < 16 && !ok; t++) begin
            @(negedge clk);
            ok = cfg_ready;
            @(posedge clk);
            #1;
        end
        if (ok) model_accept(b);
        else begin
            asserts++;
            fails++;
            $display("FAIL accept_timeout: byte %02h not accepted in 16 cycles", b);
        end
        if (gap > 0) begin
            cfg_valid = 1'b0;
            tick(gap);
        end
    endtask

    task automatic send_frame(input logic [31:0] payload, input logic [7:0] cs, input int gap);
        send_byte(SYNC, gap);
        for (int i = 0; i < CFG_BYTES; i++) send_byte(payload[8*i +: 8], gap);
        send_byte(cs, gap);
        cfg_valid = 1'b0;
    endtask

    function automatic logic [7:0] xsum(input logic [31:0] p);
        return p[7:0] ^ p[15:8] ^ p[23:16] ^ p[31:24];
    endfunction

    task automatic do_abort();
        cfg_valid = 1'b0;
        cfg_abort = 1'b1;
        tick(1);
        cfg_abort = 1'b0;
        model_abort();
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        int loads0;
        logic [31:0] p;
        logic [7:0]  cs;

        tick(2);
        check("reset_bits",  cfg_bits, 32'h0);
        check("reset_load",  {31'd0, cfg_load},  32'd0);
        check("reset_done",  {31'd0, cfg_done},  32'd0);
        check("reset_err",   {31'd0, cfg_err},   32'd0);
        check("reset_ready", {31'd0, cfg_ready}, 32'd1);
        rst_n = 1'b1;
        tick(2);

        // Good frame, one byte per cycle; image visible one edge after COMMIT.
        send_frame(32'h44332211, 8'h44, 0);
        check("good_commit_wait_ready", {31'd0, cfg_ready}, 32'd0);
        tick(1);
        check("good_load_pulse", {31'd0, cfg_load}, 32'd1);
        check("good_bits", cfg_bits, 32'h44332211);
        check_state("good");
        tick(1);
        check("good_load_fall", {31'd0, cfg_load}, 32'd0);

        // Bad checksum: image held, error sticky, loader parked.
        send_frame(32'h44332211, 8'h45, 0);
        check("bad_err", {31'd0, cfg_err}, 32'd1);
        check("bad_ready", {31'd0, cfg_ready}, 32'd0);
        tick(3);
        check_state("bad");
        check("bad_ready_held", {31'd0, cfg_ready}, 32'd0);
        do_abort();
        check("abort_err", {31'd0, cfg_err}, 32'd0);
        check("abort_ready", {31'd0, cfg_ready}, 32'd1);

        // Garbage before sync, then a frame with 3-cycle valid gaps.
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        send_byte(8'h5A, 0);
        send_frame(32'h04030201, 8'h04, 3);
        tick(2);
        check("gap_bits", cfg_bits, 32'h04030201);
        check_state("gap");

        // Abort mid-frame, then a fresh frame.
        send_byte(SYNC, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        do_abort();
        send_frame(32'h40302010, 8'h40, 0);
        tick(2);
        check("abort_mid_bits", cfg_bits, 32'h40302010);
        check_state("abort_mid");

        // Abort together with a sync byte: the byte must be dropped, so the
        // following unsynced payload must not commit.
        cfg_data  = SYNC;
        cfg_valid = 1'b1;
        cfg_abort = 1'b1;
        tick(1);
        cfg_abort = 1'b0;
        model_abort();
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        send_byte(8'h04, 0);
        send_byte(8'h04, 0);
        cfg_valid = 1'b0;
        tick(3);
        check_state("abort_same_cycle");

        // Reset mid-frame, asserted away from the clock edge.
        send_byte(SYNC, 0);
        send_byte(8'hAA, 0);
        cfg_valid = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_async_bits", cfg_bits, 32'h0);
        check("rst_async_done", {31'd0, cfg_done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_rel_bits",  cfg_bits, 32'h0);
        check("rst_rel_done",  {31'd0, cfg_done}, 32'd0);
        check("rst_rel_ready", {31'd0, cfg_ready}, 32'd1);
        @(posedge clk); #1;
        send_frame(32'hCAFE0123, xsum(32'hCAFE0123), 0);
        tick(2);
        check_state("post_rst");

        // Back-to-back frames with cfg_valid held high throughout.
        loads0      = load_count;
        ready_low   = 0;
        count_ready = 1'b1;
        send_byte(SYNC, 0);
        for (int i = 0; i < CFG_BYTES; i++) send_byte(8'h10 + 8'(i), 0);
        send_byte(8'h10 ^ 8'h11 ^ 8'h12 ^ 8'h13, 0);
        send_byte(SYNC, 0);
        for (int i = 0; i < CFG_BYTES; i++) send_byte(8'hE0 + 8'(i), 0);
        send_byte(8'hE0 ^ 8'hE1 ^ 8'hE2 ^ 8'hE3, 0);
        count_ready = 1'b0;
        cfg_valid   = 1'b0;
        tick(3);
        check("b2b_ready_low", ready_low, 32'd1);
        check("b2b_loads", load_count - loads0, 32'd2);
        check("b2b_bits", cfg_bits, 32'hE3E2E1E0);
        check_state("b2b");

        // Randomized frames: garbage, gaps, corrupt checksums, mid-frame aborts.
        for (int it = 0; it < 40; it++) begin
            int kind;
            int gap;
            kind = int'($urandom_range(0, 3));
            gap  = int'($urandom_range(0, 2));
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                logic [7:0] junk;
                junk = 8'($urandom_range(0, 255));
                if (junk == SYNC) junk = 8'h00;
                send_byte(junk, gap);
            end
            p  = $urandom;
            cs = xsum(p);
            if (kind == 1) begin
                int n;
                n = int'($urandom_range(0, CFG_BYTES - 1));
                send_byte(SYNC, gap);
                for (int i = 0; i < n; i++) send_byte(p[8*i +: 8], gap);
                do_abort();
                check_state("rnd_abort");
            end else if (kind == 0) begin
                send_frame(p, cs ^ 8'($urandom_range(1, 255)), gap);
                tick(2);
                check_state("rnd_bad");
                do_abort();
            end else begin
                send_frame(p, cs, gap);
                tick(2);
                check_state("rnd_good");
            end
        end

        tick(4);
        check("pending_loads", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    // Hard bound on simulated time.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
